// File: rtl/up_int.sv
// up_int: interrupt front-end -- synchronise and debounce event lines, latch masked rising
// edges as pending requests, and issue fixed-length interrupt pulses in fixed priority order.
module up_int #(
  parameter int N_SRC     = 4,
  parameter int DB_CYCLES = 4,
  parameter int PULSE_LEN = 2,
  parameter int HOLDOFF   = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [N_SRC-1:0] src,
  input  logic [N_SRC-1:0] mask,
  output logic             intr,
  output logic [2:0]       int_id,
  output logic [N_SRC-1:0] pending
);
  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int TMAX = PULSE_LEN > HOLDOFF ? PULSE_LEN : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;
  state_t           state, state_n;
  logic [N_SRC-1:0] s1, s2, stable, stable_d, req, rise, clr;
  logic [CW-1:0]    cnt [N_SRC];
  logic [TW-1:0]    tmr, tmr_n;
  logic [2:0]       k, id_n;
  logic             intr_n;
  // A full count means the line differed from stable for DB_CYCLES samples, so stable flips.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stable <= '0;
      for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cnt[i] == CW'(DB_CYCLES)) begin
          cnt[i]    <= '0;
          stable[i] <= ~stable[i];
        end else begin
          cnt[i] <= (s2[i] != stable[i]) ? cnt[i] + CW'(1) : '0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s1       <= '0;
      s2       <= '0;
      stable_d <= '0;
      pending  <= '0;
      state    <= IDLE;
      tmr      <= '0;
      intr     <= 1'b0;
      int_id   <= '0;
    end else begin
      s1       <= src;
      s2       <= s1;
      stable_d <= stable;
      pending  <= (pending & ~clr) | (rise & mask);
      state    <= state_n;
      tmr      <= tmr_n;
      intr     <= intr_n;
      int_id   <= id_n;
    end
  end
  // A fresh edge on the bit being issued survives the clear, so it is serviced again later.
  always_comb begin
    req     = pending & mask;
    rise    = stable & ~stable_d;
    k       = '0;
    for (int i = N_SRC - 1; i >= 0; i--) k = req[i] ? 3'(i) : k;
    state_n = state;
    tmr_n   = tmr;
    intr_n  = 1'b0;
    id_n    = int_id;
    clr     = '0;
    if (state == IDLE && |req) begin
      state_n = PULSE;
      tmr_n   = '0;
      intr_n  = 1'b1;
      id_n    = k;
      clr     = N_SRC'(1) << k;
    end else if (state == PULSE) begin
      intr_n  = tmr != TW'(PULSE_LEN - 1);
      tmr_n   = intr_n ? tmr + TW'(1) : '0;
      state_n = intr_n ? PULSE : HOLD;
    end else if (state == HOLD) begin
      tmr_n   = tmr + TW'(1);
      state_n = (tmr == TW'(HOLDOFF - 1)) ? IDLE : HOLD;
    end
  end
endmodule
